present_cipher: RTL and testbench

PRESENT_CIPHER -- requirements
Module: present_cipher

---
 rtl/present_pkg.sv | 22 ++
 rtl/present_sbox.sv | 11 +
 rtl/present_cipher.sv | 103 ++++++++++
 tb/tb_present_cipher.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared constants, state encoding and S-box table for the PRESENT-80 core.
package present_pkg;

  localparam int ROUNDS  = 31;
  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Nibble n of this constant holds S(n): 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
  localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

  function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
    logic [63:0] t;
    t = SBOX_TABLE;
    return t[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/present_sbox.sv
// 4-bit PRESENT substitution box, purely combinational.
module present_sbox
  import present_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = sbox_lookup(din);

endmodule

// File: rtl/present_cipher.sv
// PRESENT-80 encryption core: one round per enabled clock, 32 cycles from
// accepted prdy to done.
module present_cipher
  import present_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [KEY_W-1:0]   key,
  input  logic               en,
  input  logic               krdy,
  input  logic               prdy,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               done,
  output logic               start
);

  state_t             fsm;
  logic [4:0]         counter;
  logic [BLOCK_W-1:0] data;
  logic [KEY_W-1:0]   key_reg;
  logic [KEY_W-1:0]   work_key;

  logic [BLOCK_W-1:0] round_key;
  logic [BLOCK_W-1:0] added;
  logic [BLOCK_W-1:0] subbed;
  logic [BLOCK_W-1:0] perm;
  logic [KEY_W-1:0]   rot_key;
  logic [3:0]         key_top;
  logic [KEY_W-1:0]   next_key;
  logic [KEY_W-1:0]   load_key;

  assign round_key = work_key[79:16];
  assign added     = data ^ round_key;
  // A simultaneous krdy supplies the key for the block being accepted.
  assign load_key  = krdy ? key : key_reg;

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    present_sbox u_sbox (
      .din  (added[4*g +: 4]),
      .dout (subbed[4*g +: 4])
    );
  end

  always_comb begin
    perm = '0;
    for (int i = 0; i < 63; i++) begin
      perm[(16 * i) % 63] = subbed[i];
    end
    perm[63] = subbed[63];
  end

  assign rot_key = {work_key[18:0], work_key[79:19]};

  present_sbox u_key_sbox (
    .din  (rot_key[79:76]),
    .dout (key_top)
  );

  assign next_key = {key_top, rot_key[75:20], rot_key[19:15] ^ counter, rot_key[14:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm        <= ST_IDLE;
      counter    <= '0;
      data       <= '0;
      key_reg    <= '0;
      work_key   <= '0;
      ciphertext <= '0;
      done       <= 1'b0;
      start      <= 1'b0;
    end else if (en) begin
      start <= 1'b0;
      case (fsm)
        ST_IDLE, ST_DONE: begin
          if (krdy) key_reg <= key;
          if (prdy) begin
            data     <= plaintext;
            work_key <= load_key;
            counter  <= 5'd1;
            done     <= 1'b0;
            start    <= 1'b1;
            fsm      <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Counter returns to 0 after round 31; that cycle applies K32 only.
          if (counter == 5'd0) begin
            ciphertext <= added;
            done       <= 1'b1;
            fsm        <= ST_DONE;
          end else begin
            data     <= perm;
            work_key <= next_key;
            counter  <= (counter == 5'(ROUNDS)) ? 5'd0 : counter + 5'd1;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_cipher.sv
// Directed bench for present_cipher using published PRESENT-80 test vectors.
module tb_present_cipher;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] plaintext;
  logic [79:0] key;
  logic        en;
  logic        krdy;
  logic        prdy;
  logic [63:0] ciphertext;
  logic        done;
  logic        start;

  int n_vec = 0;
  int n_err = 0;

  present_cipher dut (
    .clk        (clk),
    .rst        (rst),
    .plaintext  (plaintext),
    .key        (key),
    .en         (en),
    .krdy       (krdy),
    .prdy       (prdy),
    .ciphertext (ciphertext),
    .done       (done),
    .start      (start)
  );

  always #5 clk = ~clk;

  // Launches one block and waits (bounded) for done; cycles = -1 on timeout.
  task automatic do_block(input logic [79:0] k, input logic use_krdy, input logic [63:0] pt,
                          input int stall_at, output int cycles, output int starts);
    key = k; krdy = use_krdy; plaintext = pt; prdy = 1'b1;
    @(posedge clk); #1;
    krdy = 1'b0; prdy = 1'b0;
    starts = start ? 1 : 0;
    cycles = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      starts += start ? 1 : 0;
      if (stall_at > 0 && i == stall_at) en = 1'b0;
      if (stall_at > 0 && i == stall_at + 5) en = 1'b1;
      if (done) begin
        cycles = i;
        break;
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; krdy = 1'b0; prdy = 1'b0; key = '0; plaintext = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (ciphertext !== 64'h0) begin n_err++; $display("FAIL reset_ct: got %h want 0", ciphertext); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", start); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: done %b want 0", done); end
  endtask

  task automatic test_vectors();
    logic [79:0] keys [3];
    logic [63:0] pts  [3];
    logic [63:0] exps [3];
    int cyc, st;
    keys = '{80'h0, 80'hffffffffffffffffffff, 80'h0};
    pts  = '{64'h0, 64'h0, 64'hffffffffffffffff};
    exps = '{64'h5579c1387b228445, 64'he72c46c0f5945049, 64'ha112ffc72f68417b};
    for (int v = 0; v < 3; v++) begin
      do_block(keys[v], 1'b1, pts[v], 0, cyc, st);
      n_vec++; if (ciphertext !== exps[v]) begin n_err++; $display("FAIL vec%0d_ct: got %h want %h", v, ciphertext, exps[v]); end
      n_vec++; if (cyc !== 32) begin n_err++; $display("FAIL vec%0d_latency: got %0d want 32", v, cyc); end
      n_vec++; if (st !== 1) begin n_err++; $display("FAIL vec%0d_start: got %0d pulses want 1", v, st); end
    end
  endtask

  task automatic test_key_then_prdy();
    int cyc, st;
    key = 80'hffffffffffffffffffff; krdy = 1'b1;
    @(posedge clk); #1;
    krdy = 1'b0; key = '0;
    n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL krdy_only_start: got %b want 0", start); end
    do_block(80'h0, 1'b0, 64'hffffffffffffffff, 0, cyc, st);
    n_vec++; if (ciphertext !== 64'h3333dcd3213210d2) begin n_err++; $display("FAIL key_then_prdy_ct: got %h want 3333dcd3213210d2", ciphertext); end
    n_vec++; if (st !== 1) begin n_err++; $display("FAIL key_then_prdy_start: got %0d pulses want 1", st); end
    n_vec++; if (cyc !== 32) begin n_err++; $display("FAIL key_then_prdy_latency: got %0d want 32", cyc); end
  endtask

  task automatic test_key_reuse();
    int cyc, st;
    do_block(80'h10000000000000000000, 1'b1, 64'hffffffffffffffff, 0, cyc, st);
    n_vec++; if (ciphertext !== 64'had7d5befea5c6dea) begin n_err++; $display("FAIL reuse_first_ct: got %h want ad7d5befea5c6dea", ciphertext); end
    do_block(80'h0, 1'b0, 64'h1000000000000000, 0, cyc, st);
    n_vec++; if (ciphertext !== 64'hb5cafa95bee34f40) begin n_err++; $display("FAIL reuse_second_ct: got %h want b5cafa95bee34f40", ciphertext); end
    n_vec++; if (cyc !== 32) begin n_err++; $display("FAIL reuse_latency: got %0d want 32", cyc); end
  endtask

  task automatic test_enable_stall();
    int cyc, st;
    do_block(80'h0, 1'b1, 64'h0, 10, cyc, st);
    n_vec++; if (ciphertext !== 64'h5579c1387b228445) begin n_err++; $display("FAIL stall_ct: got %h want 5579c1387b228445", ciphertext); end
    n_vec++; if (cyc !== 37) begin n_err++; $display("FAIL stall_latency: got %0d want 37", cyc); end
    n_vec++; if (st !== 1) begin n_err++; $display("FAIL stall_start: got %0d pulses want 1", st); end
  endtask

  task automatic test_ignore_strobes();
    int cyc, st;
    cyc = -1;
    key = 80'hffffffffffffffffffff; krdy = 1'b1; plaintext = 64'h0; prdy = 1'b1;
    @(posedge clk); #1;
    krdy = 1'b0; prdy = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 10) begin key = 80'h0; krdy = 1'b1; plaintext = 64'hffffffffffffffff; prdy = 1'b1; end
      if (i == 11) begin krdy = 1'b0; prdy = 1'b0; end
      if (i == 12) begin
        n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL run_prdy_start: got %b want 0", start); end
      end
      if (i == 20) begin
        n_vec++; if (ciphertext !== 64'h5579c1387b228445) begin n_err++; $display("FAIL ct_hold_in_run: got %h want 5579c1387b228445", ciphertext); end
      end
      if (done) begin
        cyc = i;
        break;
      end
    end
    n_vec++; if (ciphertext !== 64'he72c46c0f5945049) begin n_err++; $display("FAIL ignore_ct: got %h want e72c46c0f5945049", ciphertext); end
    n_vec++; if (cyc !== 32) begin n_err++; $display("FAIL ignore_latency: got %0d want 32", cyc); end
    do_block(80'h0, 1'b0, 64'h0, 0, cyc, st);
    n_vec++; if (ciphertext !== 64'he72c46c0f5945049) begin n_err++; $display("FAIL ignore_key_kept: got %h want e72c46c0f5945049", ciphertext); end
  endtask

  task automatic test_reset_abort();
    int cyc, st;
    key = 80'hffffffffffffffffffff; krdy = 1'b0; plaintext = 64'hffffffffffffffff; prdy = 1'b1;
    @(posedge clk); #1;
    prdy = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_vec++; if (ciphertext !== 64'h0) begin n_err++; $display("FAIL abort_ct: got %h want 0", ciphertext); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", done); end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    n_vec++; if (done !== 1'b0 || ciphertext !== 64'h0) begin n_err++; $display("FAIL abort_idle: done %b ct %h want 0 0", done, ciphertext); end
    do_block(80'hffffffffffffffffffff, 1'b0, 64'h0, 0, cyc, st);
    n_vec++; if (ciphertext !== 64'h5579c1387b228445) begin n_err++; $display("FAIL abort_key_cleared: got %h want 5579c1387b228445", ciphertext); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_key_then_prdy();
    test_key_reuse();
    test_enable_stall();
    test_ignore_strobes();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
